// File: rtl/mult_div_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative signed 32x32 multiply (shift-add) and divide
//               (restoring) unit with HI/LO result registers.
//               Define MULT_DIV_UNIT_DIVIDE_EN to compile the divider.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
`ifdef MULT_DIV_UNIT_DIVIDE_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [5:0]  r_cnt;
    logic        r_prep;
    logic        r_skip;
    logic        r_neg_q;
    logic [31:0] r_b;
    logic [63:0] r_acc;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [63:0] w_mul_res;

    assign w_a_mag = a[31] ? (~a + 32'd1) : a;
    assign w_b_mag = b[31] ? (~b + 32'd1) : b;

    // Multiplier sits in the low half of r_acc and is consumed LSB first.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};
    assign w_mul_res  = r_neg_q ? (~w_mul_next + 64'd1) : w_mul_next;

`ifdef MULT_DIV_UNIT_DIVIDE_EN
    logic        r_neg_r;
    logic [32:0] w_div_sh;
    logic [32:0] w_div_sub;
    logic [31:0] w_div_rem;
    logic [63:0] w_div_next;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // r_acc holds {partial remainder, dividend/quotient}; the remainder is
    // always below 2^31, so its shifted value fits in 33 bits.
    assign w_div_sh   = r_acc[63:31];
    assign w_div_sub  = w_div_sh - {1'b0, r_b};
    assign w_div_rem  = w_div_sub[32] ? w_div_sh[31:0] : w_div_sub[31:0];
    assign w_div_next = {w_div_rem, r_acc[30:0], ~w_div_sub[32]};
    assign w_quo      = r_neg_q ? (~w_div_next[31:0] + 32'd1) : w_div_next[31:0];
    assign w_rem      = r_neg_r ? (~w_div_next[63:32] + 32'd1) : w_div_next[63:32];
`endif

    // The first cycle after acceptance is a setup cycle; short operations
    // (divide by zero, divide when disabled) finish there without writing HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_cnt   <= 6'd0;
            r_prep  <= 1'b0;
            r_skip  <= 1'b0;
            r_neg_q <= 1'b0;
            r_b     <= 32'd0;
            r_acc   <= 64'd0;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
            r_neg_r <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_prep  <= 1'b1;
                        r_cnt   <= 6'd0;
                        r_neg_q <= a[31] ^ b[31];
                        r_b     <= w_b_mag;
                        r_acc   <= {32'd0, w_a_mag};
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                        r_neg_r <= a[31];
                        r_skip  <= op && (b == 32'd0);
                        r_state <= op ? S_DIV : S_MULT;
`else
                        r_skip  <= op;
                        r_state <= S_MULT;
`endif
                    end
                end
                S_MULT: begin
                    if (r_prep) begin
                        r_prep <= 1'b0;
                        if (r_skip) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_acc <= w_mul_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_hi    <= w_mul_res[63:32];
                            r_lo    <= w_mul_res[31:0];
                            r_cnt   <= 6'd0;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                S_DIV: begin
                    if (r_prep) begin
                        r_prep <= 1'b0;
                        if (r_skip) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_dz    <= 1'b1;
                        end
                    end else begin
                        r_acc <= w_div_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_hi    <= w_rem;
                            r_lo    <= w_quo;
                            r_cnt   <= 6'd0;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Scoreboard testbench for mult_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          acc_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_done = 0;
    int          n_acc = 0;
    int          acc_last = 0;
    int          acc_prev = 0;
    int          busy_drop = 0;
    logic        prev_busy = 1'b0;
    logic        prev_done = 1'b0;
    logic        in_op = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic signed [63:0] sx, sy, p, q, r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        if (!o) begin
            p = sx * sy;
            e.hi = p[63:32]; e.lo = p[31:0]; e.dz = 1'b0; e.lat = 33;
        end
`ifdef MULT_DIV_UNIT_DIVIDE_EN
        else if (y == 32'd0) begin
            e.hi = m_hi; e.lo = m_lo; e.dz = 1'b1; e.lat = 1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            e.hi = r[31:0]; e.lo = q[31:0]; e.dz = 1'b0; e.lat = 33;
        end
`else
        else begin
            e.hi = m_hi; e.lo = m_lo; e.dz = 1'b0; e.lat = 1;
        end
`endif
        m_hi = e.hi;
        m_lo = e.lo;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: detects acceptance (busy rising) and checks each done pulse.
    initial forever begin
        exp_t e;
        int   t0;
        @(negedge clk);
        if (!reset) begin
            prev_busy = 1'b0;
            prev_done = 1'b0;
            in_op     = 1'b0;
            busy_drop = 0;
        end else begin
            if (busy && !prev_busy) begin
                acc_q.push_back(cyc);
                n_acc++;
                acc_prev = acc_last;
                acc_last = cyc;
                in_op    = 1'b1;
            end
            if (in_op && !busy) busy_drop++;
            if (done) begin
                n_done++;
                check_eq("done_single", {63'd0, prev_done}, 64'd0);
                check_eq("busy_held", busy_drop, 0);
                check_eq("pending_op", {63'd0, (sb.size() > 0 && acc_q.size() > 0)}, 64'd1);
                if (sb.size() > 0 && acc_q.size() > 0) begin
                    e  = sb.pop_front();
                    t0 = acc_q.pop_front();
                    check_eq("hi", {32'd0, hi}, {32'd0, e.hi});
                    check_eq("lo", {32'd0, lo}, {32'd0, e.lo});
                    check_eq("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
                    check_eq("latency", cyc - t0, e.lat);
                end
                in_op     = 1'b0;
                busy_drop = 0;
            end else begin
                check_eq("dz_without_done", {63'd0, div_zero}, 64'd0);
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("idle_wait", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y);
        wait_idle();
        sb.push_back(model(o, x, y));
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = $urandom_range(0, 1);
    endtask

    initial begin
        int base_acc, base_done, guard;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_dz", {63'd0, div_zero}, 64'd0);
        check_eq("rst_hi", {32'd0, hi}, 64'd0);
        check_eq("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b1;

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(1'b0, 32'd2, 32'd3);
        run_op(1'b1, 32'd5, 32'd0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, $urandom, $urandom);
            run_op(1'b1, $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom);
        end

        // start held high: exactly one operation per 35-cycle window
        wait_idle();
        base_acc  = n_acc;
        base_done = n_done;
        sb.push_back(model(1'b0, 32'd1, 32'd1));
        sb.push_back(model(1'b0, 32'd1, 32'd1));
        start = 1'b1; op = 1'b0; a = 32'd1; b = 32'd1;
        guard = 0;
        while (n_acc < base_acc + 2 && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        start = 1'b0;
        check_eq("accept_count", n_acc - base_acc, 2);
        check_eq("accept_spacing", acc_last - acc_prev, 35);
        repeat (40) @(negedge clk);
        check_eq("cont_done_count", n_done - base_done, 2);

        // asynchronous reset during iteration 10 aborts the operation
        run_op(1'b0, 32'h1234_5678, 32'h10);
        repeat (10) @(negedge clk);
        base_done = n_done;
        #2 reset = 1'b0;
        #1;
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_hi", {32'd0, hi}, 64'd0);
        check_eq("abort_lo", {32'd0, lo}, 64'd0);
        sb.delete();
        acc_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("abort_no_done", n_done - base_done, 0);
        run_op(1'b0, 32'h1234_5678, 32'h10);

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("sb_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
